life_board_controller: RTL and testbench

- Initiator side of the generation-engine handshake.
- Owns the authoritative 64-cell board register (bit index = row*8 + col) and drives it to the next-state engine.
- Paces generations with a period timer and requests a new generation via write_board_state.
- Captures next_state when the engine reports writing_board_done; also handles external seed loads, single-step, still-life/extinction detection and engine timeout.

---
 rtl/life_board_controller.sv | 133 +++++++++++++
 tb/tb_life_board_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_board_controller.sv
// Game-of-Life board owner and generation pacer.
// Requests next generations from an external engine and captures its results.
module life_board_controller #(
  parameter int unsigned GEN_PERIOD = 1000000,
  parameter int unsigned TIMEOUT    = 256,
  parameter logic [63:0] INIT_BOARD = 64'h0000_0000_1C00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        load_valid,
  input  logic [63:0] load_board,
  output logic [63:0] board,
  output logic        write_board_state,
  input  logic [63:0] next_state,
  input  logic        writing_board_done,
  output logic        board_updated,
  output logic [15:0] gen_count,
  output logic        stable,
  output logic        extinct,
  output logic        engine_err
);

  localparam int TW  = $clog2(GEN_PERIOD);
  localparam int TCW = $clog2(TIMEOUT);

  localparam logic [TW-1:0]  TIMER_LAST = TW'(GEN_PERIOD - 1);
  localparam logic [TCW-1:0] TCNT_LAST  = TCW'(TIMEOUT - 1);

  typedef enum logic {
    WAIT,
    REQUEST
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [TW-1:0]  timer_q;
  logic [TW-1:0]  timer_d;
  logic [TCW-1:0] tcnt_q;
  logic [TCW-1:0] tcnt_d;
  logic           capture;
  logic           timeout;

  // Request is a pure function of state so reset drops it at once.
  assign write_board_state = (state_q == REQUEST);

  // State, period timer and engine timeout counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
      timer_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state logic; a seed load overrides everything else.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tcnt_d  = tcnt_q;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (1'b1)
      (state_q == WAIT): begin
        tcnt_d = '0;
        if (run) begin
          if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            state_d = REQUEST;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else if (step) begin
          timer_d = '0;
          state_d = REQUEST;
        end
      end
      (state_q == REQUEST): begin
        if (writing_board_done) begin
          capture = 1'b1;
          state_d = WAIT;
        end else if (tcnt_q == TCNT_LAST) begin
          timeout = 1'b1;
          state_d = WAIT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = WAIT;
    endcase
    if (load_valid) begin
      state_d = WAIT;
      timer_d = '0;
      tcnt_d  = '0;
      capture = 1'b0;
      timeout = 1'b0;
    end
  end

  // Board and status: seed load, engine capture or timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board         <= INIT_BOARD;
      board_updated <= 1'b0;
      gen_count     <= '0;
      stable        <= 1'b0;
      extinct       <= (INIT_BOARD == 64'h0);
      engine_err    <= 1'b0;
    end else begin
      board_updated <= capture;
      if (load_valid) begin
        board      <= load_board;
        gen_count  <= '0;
        stable     <= 1'b0;
        extinct    <= (load_board == 64'h0);
        engine_err <= 1'b0;
      end else if (capture) begin
        board     <= next_state;
        gen_count <= gen_count + 16'd1;
        stable    <= (next_state == board);
        extinct   <= (next_state == 64'h0);
      end else if (timeout) begin
        engine_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_board_controller.sv
// Directed bench for life_board_controller.
// Two instances: a paced one and a short-timeout one with a dead engine.
module tb_life_board_controller;

  localparam logic [63:0] INIT = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] P1   = 64'h0000_0008_0808_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step;
  logic        load_valid;
  logic [63:0] load_board;
  logic [63:0] next_state;
  logic        done;
  logic [63:0] board;
  logic        wbs;
  logic        upd;
  logic [15:0] gen;
  logic        stable;
  logic        extinct;
  logic        err;

  logic        step2;
  logic        load2;
  logic [63:0] lb2;
  logic [63:0] board2;
  logic        wbs2;
  logic        upd2;
  logic [15:0] gen2;
  logic        stable2;
  logic        extinct2;
  logic        err2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  life_board_controller #(
    .GEN_PERIOD(10),
    .TIMEOUT(256),
    .INIT_BOARD(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .step(step),
    .load_valid(load_valid),
    .load_board(load_board),
    .board(board),
    .write_board_state(wbs),
    .next_state(next_state),
    .writing_board_done(done),
    .board_updated(upd),
    .gen_count(gen),
    .stable(stable),
    .extinct(extinct),
    .engine_err(err)
  );

  life_board_controller #(
    .GEN_PERIOD(10),
    .TIMEOUT(16),
    .INIT_BOARD(INIT)
  ) dut_t (
    .clk(clk),
    .rst(rst),
    .run(1'b0),
    .step(step2),
    .load_valid(load2),
    .load_board(lb2),
    .board(board2),
    .write_board_state(wbs2),
    .next_state(64'h0),
    .writing_board_done(1'b0),
    .board_updated(upd2),
    .gen_count(gen2),
    .stable(stable2),
    .extinct(extinct2),
    .engine_err(err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub engine: answers in the n-th request cycle, returns when request drops.
  task automatic serve(input int n, input logic [63:0] ns, input int limit,
                       output int hi, output int start);
    hi = 0;
    start = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      step = 1'b0;
      done = 1'b0;
      if (wbs) begin
        hi++;
        if (hi == 1) start = cyc;
        if (hi == n) begin
          done = 1'b1;
          next_state = ns;
        end
      end else if (hi > 0) begin
        break;
      end
    end
  endtask

  initial begin
    int hi;
    int s0;
    int s1;
    int s2;
    bit seen;
    rst = 1'b1;
    run = 1'b0;
    step = 1'b0;
    load_valid = 1'b0;
    load_board = '0;
    next_state = '0;
    done = 1'b0;
    step2 = 1'b0;
    load2 = 1'b0;
    lb2 = '0;

    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_board", board, INIT);
    chk("rst_wbs", wbs, 0);
    chk("rst_gen", gen, 0);
    chk("rst_extinct", extinct, 0);
    chk("rst_stable", stable, 0);
    chk("rst_err", err, 0);
    chk("rst_upd", upd, 0);

    step = 1'b1;
    serve(64, P1, 200, hi, s0);
    chk("step_wbs_cycles", hi, 64);
    chk("step_board", board, P1);
    chk("step_upd_pulse", upd, 1);
    chk("step_gen", gen, 1);
    chk("step_stable", stable, 0);
    chk("step_wbs_low", wbs, 0);
    @(negedge clk);
    chk("step_upd_end", upd, 0);

    next_state = 64'h1;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk("wait_done_board", board, P1);
    chk("wait_done_gen", gen, 1);
    chk("wait_done_upd", upd, 0);

    run = 1'b1;
    serve(4, P1, 40, hi, s0);
    chk("run1_board", board, P1);
    chk("run1_stable", stable, 1);
    chk("run1_gen", gen, 2);
    serve(4, P1, 40, hi, s1);
    chk("run2_gen", gen, 3);
    serve(4, P1, 40, hi, s2);
    chk("run3_gen", gen, 4);
    run = 1'b0;
    chk("run_interval1", s1 - s0, 14);
    chk("run_interval2", s2 - s1, 14);

    step = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      step = 1'b0;
      if (wbs) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ld_req_seen", seen, 1);
    load_valid = 1'b1;
    load_board = 64'h0;
    done = 1'b1;
    next_state = 64'h1;
    @(negedge clk);
    load_valid = 1'b0;
    done = 1'b0;
    chk("ld_board", board, 0);
    chk("ld_extinct", extinct, 1);
    chk("ld_gen", gen, 0);
    chk("ld_wbs", wbs, 0);
    chk("ld_upd", upd, 0);
    @(negedge clk);
    chk("ld_upd_next", upd, 0);
    chk("ld_board_next", board, 0);

    step2 = 1'b1;
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      step2 = 1'b0;
      if (wbs2) hi++;
      else if (hi > 0) break;
    end
    chk("to_wbs_cycles", hi, 16);
    chk("to_err", err2, 1);
    chk("to_board", board2, INIT);
    chk("to_gen", gen2, 0);
    load2 = 1'b1;
    lb2 = 64'hFF;
    @(negedge clk);
    load2 = 1'b0;
    chk("to_ld_err", err2, 0);
    chk("to_ld_board", board2, 64'hFF);
    chk("to_ld_gen", gen2, 0);

    step = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      step = 1'b0;
      if (wbs) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rr_req_seen", seen, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_wbs", wbs, 0);
    chk("rr_board", board, INIT);
    chk("rr_extinct", extinct, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
